fetch_ctrl: RTL and testbench

Instruction-fetch sequencer owning the architectural PC. It issues word fetches to instruction memory over a req/ack handshake and holds each fetched instruction for decode under a valid/ready handshake. On handoff it computes the next PC as sequential (PC+4) or branch (PC+4+sext(imm16)<<2). It replaces the free-running negedge PC register with a reset-able, stall-aware controller between the PC datapath and decode.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_if.sv | 29 ++
 rtl/pc_next_calc.sv | 24 ++
 rtl/fetch_ctrl.sv | 96 +++++++++
 tb/tb_fetch_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch sequencer.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0020;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Instruction-memory and decode handshake bundle for fetch_ctrl.
// Revision : 1.0
// ============================================================================
interface fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        nPC_sel;
   logic [15:0] imm16;

   modport master (
      output imem_req, imem_addr, instr, pc, instr_valid,
      input  imem_ack, imem_data, instr_ready, nPC_sel, imm16
   );

   modport slave (
      input  imem_req, imem_addr, instr, pc, instr_valid,
      output imem_ack, imem_data, instr_ready, nPC_sel, imm16
   );
endinterface : fetch_if
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_calc
// Brief    : Sequential / branch next-PC adder (pc+4 plus optional word offset).
// Revision : 1.0
// ============================================================================
module pc_next_calc
   import fetch_pkg::*;
(
   input  wire logic [31:0] pc,
   input  wire logic        nPC_sel,
   input  wire logic [15:0] imm16,
   output logic      [31:0] next_pc
);

   logic [31:0] w_seq_pc;
   logic [31:0] w_offset;

   assign w_seq_pc = pc + PC_INC;
   assign w_offset = nPC_sel ? {{14{imm16[15]}}, imm16, 2'b00} : 32'd0;
   assign next_pc  = w_seq_pc + w_offset;

endmodule : pc_next_calc
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Brief    : Stall-aware fetch sequencer owning the PC; req/ack to imem,
//            valid/ready to decode.
// Revision : 1.0
// ============================================================================
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  wire logic   clk,
   input  wire logic   reset,
   input  wire logic   halt,
   fetch_if.master     bus,
   output logic [31:0] fetch_count
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_next_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic [31:0] r_fetch_count;
   logic [31:0] w_target_pc;
   logic        w_capture;
   logic        w_handoff;

   pc_next_calc u_pc_next_calc (
      .pc      (r_pc),
      .nPC_sel (bus.nPC_sel),
      .imm16   (bus.imm16),
      .next_pc (w_target_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Data registers only move on the handshake strobes decoded below.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_next_pc     <= RESET_PC;
         r_instr       <= 32'd0;
         r_pc          <= RESET_PC;
         r_fetch_count <= 32'd0;
      end else begin
         if (w_capture) begin
            r_instr <= bus.imem_data;
            r_pc    <= r_next_pc;
         end
         if (w_handoff) begin
            r_next_pc     <= w_target_pc;
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_handoff   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!halt) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (bus.imem_ack) begin
               w_capture   = 1'b1;
               w_state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (bus.instr_ready) begin
               w_handoff   = 1'b1;
               w_state_nxt = halt ? S_IDLE : S_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.imem_req    = (r_state == S_FETCH);
   assign bus.imem_addr   = r_next_pc;
   assign bus.instr_valid = (r_state == S_HOLD);
   assign bus.instr       = r_instr;
   assign bus.pc          = r_pc;
   assign fetch_count     = r_fetch_count;

endmodule : fetch_ctrl
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Brief    : Directed vector bench for fetch_ctrl, plus reset and wrap cases.
// Revision : 1.0
// ============================================================================
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset, halt;
   logic        reset2, halt2;
   logic [31:0] fetch_count, fetch_count2;
   int          n_checks = 0;
   int          n_errors = 0;

   fetch_if bus ();
   fetch_if bus2 ();

   fetch_ctrl u_dut (
      .clk         (clk),
      .reset       (reset),
      .halt        (halt),
      .bus         (bus),
      .fetch_count (fetch_count)
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk         (clk),
      .reset       (reset2),
      .halt        (halt2),
      .bus         (bus2),
      .fetch_count (fetch_count2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        halt;
      logic        ack;
      logic [31:0] data;
      logic        ready;
      logic        sel;
      logic [15:0] imm;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] ins;
      logic [31:0] pcv;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[23];

   function automatic vec_t mk(logic h, logic a, logic [31:0] d, logic r, logic s,
                               logic [15:0] i, logic q, logic [31:0] ad, logic v,
                               logic [31:0] in, logic [31:0] p, logic [31:0] c);
      vec_t t;
      t.halt = h; t.ack = a; t.data = d; t.ready = r; t.sel = s; t.imm = i;
      t.req = q; t.addr = ad; t.valid = v; t.ins = in; t.pcv = p; t.cnt = c;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic q, input logic [31:0] ad,
                            input logic v, input logic [31:0] in, input logic [31:0] p,
                            input logic [31:0] c);
      chk({tag, ".imem_req"},    {31'd0, bus.imem_req},    {31'd0, q});
      chk({tag, ".imem_addr"},   bus.imem_addr,            ad);
      chk({tag, ".instr_valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
      chk({tag, ".instr"},       bus.instr,                in);
      chk({tag, ".pc"},          bus.pc,                   p);
      chk({tag, ".fetch_count"}, fetch_count,              c);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      //              halt ack data          rdy sel imm       req addr          vld instr         pc            cnt
      vecs[0]  = mk(0, 1, 32'h0BAD_0BAD, 1, 0, 16'h0000, 0, 32'h0040_0020, 0, 32'h0,         32'h0040_0020, 0);
      vecs[1]  = mk(0, 1, 32'h1111_1111, 1, 0, 16'h0000, 1, 32'h0040_0020, 0, 32'h0,         32'h0040_0020, 0);
      vecs[2]  = mk(0, 0, 32'h0,         1, 0, 16'h0000, 0, 32'h0040_0020, 1, 32'h1111_1111, 32'h0040_0020, 0);
      vecs[3]  = mk(0, 1, 32'h2222_2222, 1, 0, 16'h0000, 1, 32'h0040_0024, 0, 32'h1111_1111, 32'h0040_0020, 1);
      vecs[4]  = mk(0, 0, 32'h0,         1, 0, 16'h0000, 0, 32'h0040_0024, 1, 32'h2222_2222, 32'h0040_0024, 1);
      vecs[5]  = mk(0, 1, 32'h3333_3333, 1, 0, 16'h0000, 1, 32'h0040_0028, 0, 32'h2222_2222, 32'h0040_0024, 2);
      vecs[6]  = mk(0, 0, 32'h0,         1, 1, 16'hFFFF, 0, 32'h0040_0028, 1, 32'h3333_3333, 32'h0040_0028, 2);
      vecs[7]  = mk(0, 0, 32'h0,         0, 0, 16'h0000, 1, 32'h0040_0028, 0, 32'h3333_3333, 32'h0040_0028, 3);
      vecs[8]  = mk(0, 0, 32'h0,         0, 0, 16'h0000, 1, 32'h0040_0028, 0, 32'h3333_3333, 32'h0040_0028, 3);
      vecs[9]  = mk(0, 0, 32'h0,         0, 0, 16'h0000, 1, 32'h0040_0028, 0, 32'h3333_3333, 32'h0040_0028, 3);
      vecs[10] = mk(0, 1, 32'h4444_4444, 0, 0, 16'h0000, 1, 32'h0040_0028, 0, 32'h3333_3333, 32'h0040_0028, 3);
      vecs[11] = mk(0, 1, 32'hEEEE_0001, 0, 1, 16'h0003, 0, 32'h0040_0028, 1, 32'h4444_4444, 32'h0040_0028, 3);
      vecs[12] = mk(0, 1, 32'hEEEE_0002, 0, 1, 16'h0003, 0, 32'h0040_0028, 1, 32'h4444_4444, 32'h0040_0028, 3);
      vecs[13] = mk(0, 0, 32'h0,         0, 0, 16'h8000, 0, 32'h0040_0028, 1, 32'h4444_4444, 32'h0040_0028, 3);
      vecs[14] = mk(0, 0, 32'h0,         0, 1, 16'h7FFF, 0, 32'h0040_0028, 1, 32'h4444_4444, 32'h0040_0028, 3);
      vecs[15] = mk(0, 0, 32'h0,         0, 0, 16'h0000, 0, 32'h0040_0028, 1, 32'h4444_4444, 32'h0040_0028, 3);
      vecs[16] = mk(1, 0, 32'h0,         1, 1, 16'h0003, 0, 32'h0040_0028, 1, 32'h4444_4444, 32'h0040_0028, 3);
      vecs[17] = mk(1, 0, 32'h0,         1, 0, 16'h0000, 0, 32'h0040_0038, 0, 32'h4444_4444, 32'h0040_0028, 4);
      vecs[18] = mk(1, 1, 32'hBEEF_BEEF, 1, 0, 16'h0000, 0, 32'h0040_0038, 0, 32'h4444_4444, 32'h0040_0028, 4);
      vecs[19] = mk(0, 0, 32'h0,         0, 0, 16'h0000, 0, 32'h0040_0038, 0, 32'h4444_4444, 32'h0040_0028, 4);
      vecs[20] = mk(1, 1, 32'h5555_5555, 0, 0, 16'h0000, 1, 32'h0040_0038, 0, 32'h4444_4444, 32'h0040_0028, 4);
      vecs[21] = mk(1, 0, 32'h0,         1, 0, 16'h0000, 0, 32'h0040_0038, 1, 32'h5555_5555, 32'h0040_0038, 4);
      vecs[22] = mk(1, 0, 32'h0,         0, 0, 16'h0000, 0, 32'h0040_003C, 0, 32'h5555_5555, 32'h0040_0038, 5);

      reset = 1'b1; halt = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_data = 32'd0; bus.instr_ready = 1'b0;
      bus.nPC_sel = 1'b0; bus.imm16 = 16'd0;
      reset2 = 1'b1; halt2 = 1'b0;
      bus2.imem_ack = 1'b1; bus2.imem_data = 32'hCAFE_F00D; bus2.instr_ready = 1'b1;
      bus2.nPC_sel = 1'b0; bus2.imm16 = 16'd0;

      tick(); tick();
      check_all("reset", 1'b0, 32'h0040_0020, 1'b0, 32'h0, 32'h0040_0020, 32'd0);
      chk("wrap.reset_addr", bus2.imem_addr, 32'hFFFF_FFFC);

      reset = 1'b0; reset2 = 1'b0;
      for (int k = 0; k < 23; k++) begin
         halt            = vecs[k].halt;
         bus.imem_ack    = vecs[k].ack;
         bus.imem_data   = vecs[k].data;
         bus.instr_ready = vecs[k].ready;
         bus.nPC_sel     = vecs[k].sel;
         bus.imm16       = vecs[k].imm;
         check_all($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr, vecs[k].valid,
                   vecs[k].ins, vecs[k].pcv, vecs[k].cnt);
         if (k == 3) begin
            chk("wrap.fetch_addr", bus2.imem_addr, 32'h0000_0000);
            chk("wrap.fetch_req", {31'd0, bus2.imem_req}, 32'd1);
            chk("wrap.held_pc", bus2.pc, 32'hFFFF_FFFC);
         end
         tick();
      end

      // Reset landing in S_FETCH together with an ack must drop the ack.
      halt = 1'b0; bus.imem_ack = 1'b0; bus.instr_ready = 1'b0;
      tick();
      chk("rst.pre_req", {31'd0, bus.imem_req}, 32'd1);
      reset = 1'b1; halt = 1'b1; bus.imem_ack = 1'b1; bus.imem_data = 32'hDEAD_BEEF;
      tick();
      reset = 1'b0;
      check_all("rst.mid", 1'b0, 32'h0040_0020, 1'b0, 32'h0, 32'h0040_0020, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("rst.halted%0d.req", k), {31'd0, bus.imem_req}, 32'd0);
         chk($sformatf("rst.halted%0d.instr", k), bus.instr, 32'h0);
      end
      halt = 1'b0; bus.imem_ack = 1'b0;
      tick();
      chk("rst.release.req", {31'd0, bus.imem_req}, 32'd1);
      chk("rst.release.addr", bus.imem_addr, 32'h0040_0020);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_fetch_ctrl
`default_nettype wire
